// File: rtl/mem_dump_reader_if.sv
// Bundles the dump reader's control, memory read port and byte-stream handshake.
// The master side is the reader; the slave side is the debug unit / memory / UART.
interface mem_dump_reader_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                  i_start;
    logic                  o_busy;
    logic                  o_done;
    logic [DATA_WIDTH-1:0] o_mem_address;
    logic                  o_mem_read;
    logic [DATA_WIDTH-1:0] i_mem_data;
    logic [7:0]            o_tx_data;
    logic                  o_tx_valid;
    logic                  i_tx_ready;

    modport master (
        input  i_start,
        output o_busy,
        output o_done,
        output o_mem_address,
        output o_mem_read,
        input  i_mem_data,
        output o_tx_data,
        output o_tx_valid,
        input  i_tx_ready
    );

    modport slave (
        output i_start,
        input  o_busy,
        input  o_done,
        input  o_mem_address,
        input  o_mem_read,
        output i_mem_data,
        input  o_tx_data,
        input  o_tx_valid,
        output i_tx_ready
    );
endinterface

// File: rtl/mem_dump_reader.sv
// Sweeps NUM_WORDS words of data memory from address 0 and streams each one
// as four bytes, MSB first, to the UART transmitter. All outputs are registered.
module mem_dump_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 32
) (
    input  logic               i_clock,
    input  logic               i_reset,
    mem_dump_reader_if.master  bus
);
    localparam int WI_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int PAD_W = DATA_WIDTH - WI_W - 2;
    localparam logic [WI_W-1:0] LAST_IDX = WI_W'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_LATCH = 3'd2,
        ST_SEND  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                state_r, state_s;
    logic [WI_W-1:0]       word_index_r, word_index_s;
    logic [1:0]            byte_cnt_r, byte_cnt_s;
    logic [DATA_WIDTH-1:0] shift_r, shift_s;

    logic                  busy_r, busy_s;
    logic                  done_r, done_s;
    logic                  mem_read_r, mem_read_s;
    logic [DATA_WIDTH-1:0] mem_address_r, mem_address_s;
    logic                  tx_valid_r, tx_valid_s;
    logic [7:0]            tx_data_r, tx_data_s;

    // Next-state logic: sequences read, latch and the four byte handshakes per word
    always_comb begin
        state_s      = state_r;
        word_index_s = word_index_r;
        byte_cnt_s   = byte_cnt_r;
        shift_s      = shift_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.i_start) begin
                    state_s      = ST_READ;
                    word_index_s = {WI_W{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                state_s = ST_LATCH;
            end
            ST_LATCH: begin
                shift_s    = bus.i_mem_data;
                byte_cnt_s = 2'd0;
                state_s    = ST_SEND;
            end
            ST_SEND: begin
                if (bus.i_tx_ready) begin
                    shift_s    = {shift_r[DATA_WIDTH-9:0], 8'h00};
                    byte_cnt_s = byte_cnt_r + 2'd1;
                    if (byte_cnt_r == 2'd3) begin
                        if (word_index_r == LAST_IDX) begin
                            state_s = ST_DONE;
                        end else begin
                            word_index_s = word_index_r + WI_W'(1'b1);
                            state_s      = ST_READ;
                        end
                    end else begin
                        state_s = ST_SEND;
                    end
                end else begin
                    state_s = ST_SEND;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output values derived from the upcoming state so they can be registered
    always_comb begin
        busy_s        = (state_s != ST_IDLE);
        done_s        = (state_s == ST_DONE);
        mem_read_s    = 1'b0;
        mem_address_s = {DATA_WIDTH{1'b0}};
        tx_valid_s    = 1'b0;
        tx_data_s     = 8'h00;
        if (state_s == ST_READ) begin
            mem_read_s    = 1'b1;
            mem_address_s = {{PAD_W{1'b0}}, word_index_s, 2'b00};
        end else begin
            mem_read_s    = 1'b0;
            mem_address_s = {DATA_WIDTH{1'b0}};
        end
        if (state_s == ST_SEND) begin
            tx_valid_s = 1'b1;
            tx_data_s  = shift_s[DATA_WIDTH-1 -: 8];
        end else begin
            tx_valid_s = 1'b0;
            tx_data_s  = 8'h00;
        end
    end

    // State, datapath and output registers
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_r       <= ST_IDLE;
            word_index_r  <= {WI_W{1'b0}};
            byte_cnt_r    <= 2'd0;
            shift_r       <= {DATA_WIDTH{1'b0}};
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            mem_read_r    <= 1'b0;
            mem_address_r <= {DATA_WIDTH{1'b0}};
            tx_valid_r    <= 1'b0;
            tx_data_r     <= 8'h00;
        end else begin
            state_r       <= state_s;
            word_index_r  <= word_index_s;
            byte_cnt_r    <= byte_cnt_s;
            shift_r       <= shift_s;
            busy_r        <= busy_s;
            done_r        <= done_s;
            mem_read_r    <= mem_read_s;
            mem_address_r <= mem_address_s;
            tx_valid_r    <= tx_valid_s;
            tx_data_r     <= tx_data_s;
        end
    end

    assign bus.o_busy        = busy_r;
    assign bus.o_done        = done_r;
    assign bus.o_mem_read    = mem_read_r;
    assign bus.o_mem_address = mem_address_r;
    assign bus.o_tx_valid    = tx_valid_r;
    assign bus.o_tx_data     = tx_data_r;
endmodule

// File: tb/tb_mem_dump_reader.sv
// Directed bench for mem_dump_reader: a 2-word instance with a fixed image and
// a default 32-word instance whose memory holds word k at address k*4.
module tb_mem_dump_reader;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_dump_reader_if #(.DATA_WIDTH(32)) bus_a ();
    mem_dump_reader_if #(.DATA_WIDTH(32)) bus_b ();

    mem_dump_reader #(.DATA_WIDTH(32), .NUM_WORDS(2)) dut_a (
        .i_clock(clk), .i_reset(rst), .bus(bus_a)
    );
    mem_dump_reader #(.DATA_WIDTH(32), .NUM_WORDS(32)) dut_b (
        .i_clock(clk), .i_reset(rst), .bus(bus_b)
    );

    function automatic logic [31:0] mem_a_word(input logic [31:0] addr);
        case (addr)
            32'h0:   return 32'h11223344;
            32'h4:   return 32'hAABBCCDD;
            default: return 32'hDEADBEEF;
        endcase
    endfunction

    // Synchronous-read memories
    always @(posedge clk) begin
        if (bus_a.o_mem_read) bus_a.i_mem_data <= mem_a_word(bus_a.o_mem_address);
        if (bus_b.o_mem_read) bus_b.i_mem_data <= {2'b00, bus_b.o_mem_address[31:2]};
    end

    int total = 0;
    int bad   = 0;
    int cyc_no = 0;
    logic [7:0]  bytes_a[$];
    logic [31:0] addrs_a[$];
    logic [7:0]  bytes_b[$];
    logic [31:0] addrs_b[$];
    int done_a, done_at_a, busy_a, first_read_a, first_valid_a;
    int done_b, done_at_b, busy_b;
    logic [7:0] exp_a [0:7] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic clear_logs();
        bytes_a.delete(); addrs_a.delete(); bytes_b.delete(); addrs_b.delete();
        done_a = 0; done_at_a = 0; busy_a = 0; first_read_a = -1; first_valid_a = -1;
        done_b = 0; done_at_b = 0; busy_b = 0;
    endtask

    // Called at a negedge with inputs already set for the coming posedge
    task automatic cyc();
        if (bus_a.o_busy) busy_a++;
        if (bus_a.o_done) begin done_a++; done_at_a = busy_a; end
        if (bus_a.o_mem_read) begin
            addrs_a.push_back(bus_a.o_mem_address);
            if (first_read_a < 0) first_read_a = cyc_no;
        end
        if (bus_a.o_tx_valid) begin
            if (first_valid_a < 0) first_valid_a = cyc_no;
            if (bus_a.i_tx_ready) bytes_a.push_back(bus_a.o_tx_data);
        end
        if (bus_b.o_busy) busy_b++;
        if (bus_b.o_done) begin done_b++; done_at_b = busy_b; end
        if (bus_b.o_mem_read) addrs_b.push_back(bus_b.o_mem_address);
        if (bus_b.o_tx_valid && bus_b.i_tx_ready) bytes_b.push_back(bus_b.o_tx_data);
        cyc_no++;
        @(negedge clk);
    endtask

    task automatic check_zero_a(input string tag);
        chk({tag, "_busy"},  {31'd0, bus_a.o_busy}, 32'd0);
        chk({tag, "_done"},  {31'd0, bus_a.o_done}, 32'd0);
        chk({tag, "_rd"},    {31'd0, bus_a.o_mem_read}, 32'd0);
        chk({tag, "_addr"},  bus_a.o_mem_address, 32'd0);
        chk({tag, "_valid"}, {31'd0, bus_a.o_tx_valid}, 32'd0);
        chk({tag, "_data"},  {24'd0, bus_a.o_tx_data}, 32'd0);
    endtask

    task automatic check_stream_a(input string tag);
        logic [7:0] got;
        chk({tag, "_nbytes"}, bytes_a.size(), 32'd8);
        for (int i = 0; i < 8; i++) begin
            got = 8'hxx;
            if (i < bytes_a.size()) got = bytes_a[i];
            chk($sformatf("%s_byte%0d", tag, i), {24'd0, got}, {24'd0, exp_a[i]});
        end
    endtask

    function automatic logic [7:0] byte_b(input int i);
        if (i < bytes_b.size()) return bytes_b[i];
        else return 8'hxx;
    endfunction

    initial begin
        int s;
        logic [31:0] a0;
        rst = 1'b0;
        bus_a.i_start = 1'b0; bus_a.i_tx_ready = 1'b0;
        bus_b.i_start = 1'b0; bus_b.i_tx_ready = 1'b1;
        clear_logs();

        // Reset then idle
        repeat (3) @(negedge clk);
        rst = 1'b1;
        check_zero_a("rst");
        for (int i = 0; i < 4; i++) begin
            bus_a.i_tx_ready = i[0];
            cyc();
        end
        chk("idle_busy",  {31'd0, bus_a.o_busy}, 32'd0);
        chk("idle_valid", {31'd0, bus_a.o_tx_valid}, 32'd0);
        chk("idle_bytes", busy_a + bytes_a.size(), 32'd0);

        // Basic dump with latency checks
        clear_logs();
        bus_a.i_tx_ready = 1'b1;
        s = cyc_no;
        bus_a.i_start = 1'b1; cyc(); bus_a.i_start = 1'b0;
        repeat (19) cyc();
        chk("lat_read",  first_read_a,  s + 1);
        chk("lat_valid", first_valid_a, s + 3);
        chk("basic_nrd", addrs_a.size(), 32'd2);
        a0 = 32'hxxxxxxxx; if (addrs_a.size() > 0) a0 = addrs_a[0];
        chk("basic_addr0", a0, 32'h0);
        a0 = 32'hxxxxxxxx; if (addrs_a.size() > 1) a0 = addrs_a[1];
        chk("basic_addr1", a0, 32'h4);
        check_stream_a("basic");
        chk("basic_ndone",   done_a, 32'd1);
        chk("basic_done_at", done_at_a, 32'd13);
        chk("basic_busy",    busy_a, 32'd13);

        // Backpressure on the third byte
        clear_logs();
        bus_a.i_start = 1'b1; cyc(); bus_a.i_start = 1'b0;
        for (int i = 0; i < 20 && bytes_a.size() < 2; i++) cyc();
        chk("bp_pre", bytes_a.size(), 32'd2);
        bus_a.i_tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_data",  {24'd0, bus_a.o_tx_data}, 32'h33);
            chk("bp_hold_valid", {31'd0, bus_a.o_tx_valid}, 32'd1);
            cyc();
        end
        chk("bp_nodup", bytes_a.size(), 32'd2);
        bus_a.i_tx_ready = 1'b1;
        repeat (20) cyc();
        check_stream_a("bp");
        chk("bp_ndone", done_a, 32'd1);

        // Start while busy: mid-SEND and in the DONE cycle
        clear_logs();
        bus_a.i_start = 1'b1; cyc();
        for (int i = 0; i < 25; i++) begin
            bus_a.i_start = (i == 4) || bus_a.o_done;
            cyc();
        end
        bus_a.i_start = 1'b0;
        chk("sb_nrd",   addrs_a.size(), 32'd2);
        chk("sb_ndone", done_a, 32'd1);
        chk("sb_busy",  busy_a, 32'd13);
        chk("sb_idle",  {31'd0, bus_a.o_busy}, 32'd0);
        check_stream_a("sb");

        // Asynchronous reset after the fifth byte
        clear_logs();
        bus_a.i_start = 1'b1; cyc(); bus_a.i_start = 1'b0;
        for (int i = 0; i < 30 && bytes_a.size() < 5; i++) cyc();
        chk("mr_pre", bytes_a.size(), 32'd5);
        #2 rst = 1'b0;
        #1 check_zero_a("mr_async");
        @(negedge clk);
        repeat (2) cyc();
        chk("mr_nodone", done_a, 32'd0);
        rst = 1'b1;
        clear_logs();
        bus_a.i_start = 1'b1; cyc(); bus_a.i_start = 1'b0;
        repeat (19) cyc();
        a0 = 32'hxxxxxxxx; if (addrs_a.size() > 0) a0 = addrs_a[0];
        chk("mr_addr0", a0, 32'h0);
        check_stream_a("mr");
        chk("mr_ndone", done_a, 32'd1);

        // Full default-size dump
        clear_logs();
        bus_b.i_start = 1'b1; cyc(); bus_b.i_start = 1'b0;
        repeat (200) cyc();
        chk("full_nbytes", bytes_b.size(), 32'd128);
        for (int k = 0; k < 32; k++) begin
            chk($sformatf("full_word%0d", k),
                {byte_b(4*k), byte_b(4*k+1), byte_b(4*k+2), byte_b(4*k+3)}, k);
        end
        chk("full_nrd", addrs_b.size(), 32'd32);
        a0 = 32'hxxxxxxxx; if (addrs_b.size() > 0) a0 = addrs_b[addrs_b.size()-1];
        chk("full_last_addr", a0, 32'h7C);
        chk("full_ndone",   done_b, 32'd1);
        chk("full_done_at", done_at_b, 32'd193);
        chk("full_busy",    busy_b, 32'd193);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_dump_reader.md
Name: mem_dump_reader

Overview:
- Debug-side reader of the data memory, driven on the memory's read port instead of the pipeline.
- While the pipeline is halted, it sweeps NUM_WORDS consecutive 32-bit words starting at byte address 0.
- It serialises each word as 4 bytes, MSB first, onto a byte-stream handshake feeding the UART transmitter.
- It sits beside the MEM stage; the debug unit muxes o_mem_* over the pipeline's memory controls while o_busy is high.

Parameters:
- DATA_WIDTH, 32, memory word width; must be 32.
- NUM_WORDS, 32, number of words dumped (1..2^16).

Ports:
- i_clock  input  1  system clock, rising edge.
- i_reset  input  1  asynchronous, active-low reset.
- i_start  input  1  single-cycle request to begin a dump; ignored unless in IDLE.
- o_busy  output  1  high in every state except IDLE.
- o_done  output  1  one-cycle pulse after the last byte of the dump is accepted.
- o_mem_address  output  DATA_WIDTH  byte address to data memory, equal to word_index*4.
- o_mem_read  output  1  memory read strobe, full-word, unsigned access.
- i_mem_data  input  DATA_WIDTH  memory read data, valid one cycle after o_mem_read.
- o_tx_data  output  8  byte to transmit.
- o_tx_valid  output  1  o_tx_data is valid.
- i_tx_ready  input  1  consumer accepts the byte when both o_tx_valid and i_tx_ready are high at a rising edge.

Behaviour:
- Reset (asynchronous, i_reset=0):
  - State goes to IDLE.
  - word_index=0, byte_cnt=0, shift register=0.
  - All outputs are 0.
  - Reset mid-dump abandons the dump; no o_done is produced.
- States: IDLE, READ, LATCH, SEND, DONE.
- IDLE:
  - i_start=1 -> READ; word_index=0.
- READ (1 cycle):
  - o_mem_read=1 and o_mem_address={word_index,2'b00}.
  - Next state is LATCH.
- LATCH (1 cycle):
  - o_mem_read=0.
  - shift register <= i_mem_data; byte_cnt<=0.
  - Next state is SEND.
- SEND:
  - o_tx_valid=1 and o_tx_data=shift[31:24].
  - On handshake: shift<<=8 and byte_cnt++.
  - When the 4th byte is accepted (byte_cnt==3 at handshake):
    - if word_index==NUM_WORDS-1 -> DONE;
    - else word_index++ -> READ.
  - Without i_tx_ready, o_tx_valid and o_tx_data hold stable indefinitely.
- DONE (1 cycle):
  - o_done=1, then -> IDLE.
  - o_busy=1 during DONE and drops in the following cycle.
- Latency:
  - i_start sampled at edge k: READ during cycle k+1, LATCH k+2, first o_tx_valid in cycle k+3.
  - With i_tx_ready held at 1, each word costs 6 cycles (READ, LATCH, 4 SEND).
  - Full dump = 6*NUM_WORDS + 1 cycles of o_busy.
- Boundaries:
  - i_start while busy, including in the DONE cycle, is ignored and not queued.
  - NUM_WORDS=1: one word is sent, then DONE.
  - o_mem_address reads 0 outside READ.
  - i_mem_data is only sampled in LATCH; i_tx_ready outside SEND has no effect.
  - byte_cnt is 2 bits; word_index width is clog2(NUM_WORDS), minimum 1. Wrap-around never occurs because the sweep stops at NUM_WORDS-1.
- Memory model contract:
  - Synchronous read, data registered on the edge ending the READ cycle.
  - The dump never writes memory.

Test Plan:
- Reset then idle: hold i_reset=0 for 3 cycles, release -> all outputs 0, o_busy=0; i_tx_ready toggling has no effect.
- Basic dump, NUM_WORDS=2, mem[0]=0x11223344, mem[4]=0xAABBCCDD, i_tx_ready=1, pulse i_start:
  - o_mem_read at addresses 0x0 then 0x4;
  - byte stream 11,22,33,44,AA,BB,CC,DD;
  - o_done pulses exactly once, 13 cycles after the first o_busy cycle.
- Backpressure: same image, i_tx_ready low for 5 cycles on the 3rd byte -> o_tx_data holds 0x33 with o_tx_valid=1 throughout; no byte is duplicated or dropped; the stream is unchanged.
- Start while busy: pulse i_start again mid-SEND and in the DONE cycle -> no restart, o_mem_read count stays 2, single o_done.
- Reset mid-dump: assert i_reset asynchronously after the 5th byte is accepted -> outputs 0 immediately. A new i_start restarts from address 0x0 with byte 0x11.
- Default NUM_WORDS=32, mem[k*4]=k: 128 bytes, each word sent as 00,00,00,k; last address 0x7C; o_done after 193 busy cycles.
